// File: rtl/cdc_pulse_scheduler.sv
// cdc_pulse_scheduler: shares one clka->clkb toggle/ID crossing among N_REQ
// clka requesters. Round-robin launch, level-compare ack, timeout and guard gap.
module cdc_pulse_scheduler #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic             rst,
  input  logic             clka,
  input  logic [N_REQ-1:0] req_a,
  input  logic             ack_tgl_b,
  output logic             xfer_tgl,
  output logic [ID_W-1:0]  xfer_id,
  output logic             busy,
  output logic [N_REQ-1:0] done_a,
  output logic [N_REQ-1:0] ovf_a,
  output logic             tmo_a
);

  localparam int unsigned TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TMO_LAST = TIMEOUT - 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_GAP      = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [N_REQ-1:0]       pending_q, pending_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                   xfer_tgl_q, xfer_tgl_d;
  logic [ID_W-1:0]        xfer_id_q, xfer_id_d;
  logic                   busy_q, busy_d;
  logic [N_REQ-1:0]       done_q, done_d;
  logic [N_REQ-1:0]       ovf_q, ovf_d;
  logic                   tmo_q, tmo_d;
  logic [ID_W-1:0]        last_grant_q, last_grant_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;

  logic                   ack_s_c;
  logic                   launch_c;
  logic                   arb_lo_vld_c, arb_hi_vld_c;
  logic [ID_W-1:0]        arb_lo_id_c, arb_hi_id_c;
  logic                   win_vld_c;
  logic [ID_W-1:0]        win_id_c;

  assign ack_s_c = ack_sync_q[SYNC_STAGES-1];

  // Round-robin pick: lowest pending index above last_grant, else lowest overall.
  always_comb begin
    arb_lo_vld_c = 1'b0;
    arb_hi_vld_c = 1'b0;
    arb_lo_id_c  = '0;
    arb_hi_id_c  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pending_q[i]) begin
        if (!arb_lo_vld_c) begin
          arb_lo_vld_c = 1'b1;
          arb_lo_id_c  = ID_W'(i);
        end
        if (!arb_hi_vld_c && (ID_W'(i) > last_grant_q)) begin
          arb_hi_vld_c = 1'b1;
          arb_hi_id_c  = ID_W'(i);
        end
      end
    end
    win_vld_c = arb_lo_vld_c;
    win_id_c  = arb_hi_vld_c ? arb_hi_id_c : arb_lo_id_c;
  end

  // Next-state, launch, ack/timeout/gap handling and pending bookkeeping.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | req_a;
    ack_sync_d   = {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_b};
    xfer_tgl_d   = xfer_tgl_q;
    xfer_id_d    = xfer_id_q;
    busy_d       = busy_q;
    done_d       = '0;
    ovf_d        = '0;
    tmo_d        = 1'b0;
    last_grant_d = last_grant_q;
    tmo_cnt_d    = tmo_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    launch_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_vld_c) begin
          launch_c     = 1'b1;
          xfer_tgl_d   = ~xfer_tgl_q;
          xfer_id_d    = win_id_c;
          last_grant_d = win_id_c;
          tmo_cnt_d    = '0;
          busy_d       = 1'b1;
          state_d      = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if ((ack_s_c == xfer_tgl_q) || (tmo_cnt_q == TMO_W'(TMO_LAST))) begin
          if (ack_s_c == xfer_tgl_q) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
              if (xfer_id_q == ID_W'(i)) done_d[i] = 1'b1;
            end
          end else begin
            tmo_d = 1'b1;
          end
          gap_cnt_d = '0;
          if (GAP_CYCLES == 0) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A launched slot re-queues only if requested on the launch edge;
    // a request hitting an already pending slot is dropped and flagged.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (launch_c && (win_id_c == ID_W'(i))) begin
        pending_d[i] = req_a[i];
      end else if (pending_q[i] && req_a[i]) begin
        ovf_d[i] = 1'b1;
      end
    end
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      ack_sync_q   <= '0;
      xfer_tgl_q   <= 1'b0;
      xfer_id_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= '0;
      ovf_q        <= '0;
      tmo_q        <= 1'b0;
      last_grant_q <= ID_W'(N_REQ - 1);
      tmo_cnt_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      ack_sync_q   <= ack_sync_d;
      xfer_tgl_q   <= xfer_tgl_d;
      xfer_id_q    <= xfer_id_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      tmo_q        <= tmo_d;
      last_grant_q <= last_grant_d;
      tmo_cnt_q    <= tmo_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign xfer_tgl = xfer_tgl_q;
  assign xfer_id  = xfer_id_q;
  assign busy     = busy_q;
  assign done_a   = done_q;
  assign ovf_a    = ovf_q;
  assign tmo_a    = tmo_q;

endmodule

// File: tb/tb_cdc_pulse_scheduler.sv
// Directed bench for cdc_pulse_scheduler with clka- and clkb-domain ack responders.
module tb_cdc_pulse_scheduler;

  logic       rst;
  logic       clka;
  logic       clkb;
  logic [3:0] req_a;
  logic       ack_tgl_b;
  logic       xfer_tgl;
  logic [1:0] xfer_id;
  logic       busy;
  logic [3:0] done_a;
  logic [3:0] ovf_a;
  logic       tmo_a;

  cdc_pulse_scheduler #(
    .N_REQ(4), .ID_W(2), .SYNC_STAGES(2), .GAP_CYCLES(2), .TIMEOUT(64)
  ) dut (
    .rst(rst), .clka(clka), .req_a(req_a), .ack_tgl_b(ack_tgl_b),
    .xfer_tgl(xfer_tgl), .xfer_id(xfer_id), .busy(busy),
    .done_a(done_a), .ovf_a(ovf_a), .tmo_a(tmo_a)
  );

  initial clka = 1'b0;
  always #10 clka = ~clka;
  initial clkb = 1'b0;
  always #3 clkb = ~clkb;

  // Ack responders: clka model echoes xfer_tgl 3 clka cycles later (when enabled);
  // clkb model echoes through a 2-flop clkb synchroniser.
  logic ack_en, use_b;
  logic d1, d2, ack_a_q;
  logic b1, b2, ack_b_q;

  always @(posedge clka or negedge rst) begin
    if (!rst) begin
      d1 <= 1'b0; d2 <= 1'b0; ack_a_q <= 1'b0;
    end else begin
      d1 <= xfer_tgl;
      d2 <= d1;
      if (ack_en) ack_a_q <= d2;
    end
  end

  always @(posedge clkb or negedge rst) begin
    if (!rst) begin
      b1 <= 1'b0; b2 <= 1'b0; ack_b_q <= 1'b0;
    end else begin
      b1 <= xfer_tgl;
      b2 <= b1;
      ack_b_q <= b2;
    end
  end

  assign ack_tgl_b = use_b ? ack_b_q : ack_a_q;

  // Event monitor on the falling clka edge.
  int         done_tot = 0;
  int         ovf_tot  = 0;
  int         tmo_tot  = 0;
  int         id_viol  = 0;
  int         launch_n = 0;
  int         done_cnt [4] = '{0, 0, 0, 0};
  logic [1:0] launch_log [128];
  logic       prev_busy = 1'b0;
  logic [1:0] prev_id   = 2'd0;

  always @(negedge clka) begin
    done_tot <= done_tot + $countones(done_a);
    ovf_tot  <= ovf_tot + $countones(ovf_a);
    tmo_tot  <= tmo_tot + (tmo_a ? 1 : 0);
    for (int i = 0; i < 4; i++) begin
      if (done_a[i]) done_cnt[i] <= done_cnt[i] + 1;
    end
    if (busy && !prev_busy && launch_n < 128) begin
      launch_log[launch_n] <= xfer_id;
      launch_n <= launch_n + 1;
    end
    if (busy && prev_busy && (xfer_id !== prev_id)) id_viol <= id_viol + 1;
    prev_busy <= busy;
    prev_id   <= xfer_id;
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clka);
      #1;
    end
  endtask

  task automatic wait_done(input int target, input int limit, input string tag);
    int k;
    k = 0;
    while (done_tot < target && k < limit) begin
      step(1);
      k++;
    end
    chk(tag, 32'(done_tot >= target), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int         base_done, base_ovf, base_tmo, base_l;
  int         base_cnt [4];
  int         accepted;
  logic [3:0] model_pend;
  logic [3:0] r;
  logic       prev_tgl;

  initial begin
    rst    = 1'b0;
    req_a  = '0;
    ack_en = 1'b1;
    use_b  = 1'b0;

    // Reset state
    step(1);
    chk("rst_xfer_tgl", 32'(xfer_tgl), 32'd0);
    chk("rst_xfer_id",  32'(xfer_id),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_flags",    32'({done_a, ovf_a, tmo_a}), 32'd0);
    step(2);
    rst = 1'b1;
    step(2);

    // T2 round-robin: all four at once, fresh pointer -> 0,1,2,3
    base_done = done_tot; base_ovf = ovf_tot; base_l = launch_n;
    for (int i = 0; i < 4; i++) base_cnt[i] = done_cnt[i];
    req_a = 4'b1111;
    step(1);
    req_a = '0;
    step(1);
    chk("t2_first_id",  32'(xfer_id),  32'd0);
    chk("t2_first_tgl", 32'(xfer_tgl), 32'd1);
    chk("t2_first_busy", 32'(busy),    32'd1);
    wait_done(base_done + 4, 80, "t2_wait");
    step(6);
    for (int k = 0; k < 4; k++) chk("t2_order", 32'(launch_log[base_l + k]), 32'(k));
    for (int i = 0; i < 4; i++) chk("t2_done_per_req", 32'(done_cnt[i] - base_cnt[i]), 32'd1);
    chk("t2_done_total", 32'(done_tot - base_done), 32'd4);
    chk("t2_no_ovf",     32'(ovf_tot - base_ovf),   32'd0);

    // T1 single request from requester 2
    base_done = done_tot;
    req_a = 4'b0100;
    step(1);
    req_a = '0;
    chk("t1_idle_busy", 32'(busy),     32'd0);
    chk("t1_tgl_before", 32'(xfer_tgl), 32'd0);
    step(1);
    chk("t1_tgl_after", 32'(xfer_tgl), 32'd1);
    chk("t1_id",        32'(xfer_id),  32'd2);
    chk("t1_busy",      32'(busy),     32'd1);
    step(5);
    chk("t1_done_early", 32'(done_a), 32'd0);
    step(1);
    chk("t1_done",       32'(done_a), 32'b0100);
    step(1);
    chk("t1_done_pulse", 32'(done_a), 32'd0);
    chk("t1_busy_gap",   32'(busy),   32'd1);
    step(2);
    chk("t1_busy_low",   32'(busy),   32'd0);
    step(3);

    // T3 overflow: requester 1 requested twice while pending behind 0
    base_done = done_tot; base_ovf = ovf_tot; base_l = launch_n;
    for (int i = 0; i < 4; i++) base_cnt[i] = done_cnt[i];
    req_a = 4'b0001;
    step(1);
    req_a = '0;
    step(1);
    chk("t3_launch0", 32'(xfer_id), 32'd0);
    req_a = 4'b0010;
    step(1);
    chk("t3_no_ovf_first", 32'(ovf_a), 32'd0);
    req_a = 4'b0010;
    step(1);
    req_a = '0;
    chk("t3_ovf",       32'(ovf_a), 32'b0010);
    step(1);
    chk("t3_ovf_pulse", 32'(ovf_a), 32'd0);
    wait_done(base_done + 2, 60, "t3_wait");
    step(6);
    chk("t3_ovf_count",  32'(ovf_tot - base_ovf), 32'd1);
    chk("t3_done_req1",  32'(done_cnt[1] - base_cnt[1]), 32'd1);
    chk("t3_done_total", 32'(done_tot - base_done), 32'd2);
    chk("t3_order0",     32'(launch_log[base_l]),     32'd0);
    chk("t3_order1",     32'(launch_log[base_l + 1]), 32'd1);

    // T4 timeout, late ack, then a clean transfer
    ack_en = 1'b0;
    base_done = done_tot; base_tmo = tmo_tot;
    req_a = 4'b0001;
    step(1);
    req_a = '0;
    step(1);
    chk("t4_busy",  32'(busy),     32'd1);
    chk("t4_tgl",   32'(xfer_tgl), 32'd0);
    step(63);
    chk("t4_tmo_early", 32'(tmo_a), 32'd0);
    chk("t4_busy_wait", 32'(busy),  32'd1);
    step(1);
    chk("t4_tmo",       32'(tmo_a),  32'd1);
    chk("t4_tmo_nodone", 32'(done_a), 32'd0);
    step(1);
    chk("t4_tmo_pulse", 32'(tmo_a), 32'd0);
    step(2);
    chk("t4_busy_low",  32'(busy),  32'd0);
    chk("t4_tmo_count", 32'(tmo_tot - base_tmo), 32'd1);
    ack_en = 1'b1;
    step(6);
    chk("t4_late_nodone", 32'(done_tot - base_done), 32'd0);
    chk("t4_late_idle",   32'(busy), 32'd0);
    req_a = 4'b0001;
    step(1);
    req_a = '0;
    step(1);
    chk("t4_relaunch_tgl", 32'(xfer_tgl), 32'd1);
    chk("t4_relaunch_id",  32'(xfer_id),  32'd0);
    step(5);
    chk("t4_no_false_done", 32'(done_tot - base_done), 32'd0);
    chk("t4_done_early",    32'(done_a), 32'd0);
    step(1);
    chk("t4_done", 32'(done_a), 32'b0001);
    step(6);

    // T5 reset during WAIT_ACK
    base_done = done_tot; base_tmo = tmo_tot;
    for (int i = 0; i < 4; i++) base_cnt[i] = done_cnt[i];
    req_a = 4'b1000;
    step(1);
    req_a = '0;
    step(1);
    chk("t5_inflight_id",   32'(xfer_id), 32'd3);
    chk("t5_inflight_busy", 32'(busy),    32'd1);
    step(1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_busy",  32'(busy),     32'd0);
    chk("t5_rst_id",    32'(xfer_id),  32'd0);
    chk("t5_rst_tgl",   32'(xfer_tgl), 32'd0);
    chk("t5_rst_flags", 32'({done_a, ovf_a, tmo_a}), 32'd0);
    step(2);
    rst = 1'b1;
    step(2);
    chk("t5_abandon_nodone", 32'(done_tot - base_done), 32'd0);
    chk("t5_abandon_notmo",  32'(tmo_tot - base_tmo),   32'd0);
    req_a = 4'b1000;
    step(1);
    chk("t5_pre_tgl", 32'(xfer_tgl), 32'd0);
    req_a = '0;
    step(1);
    chk("t5_post_tgl", 32'(xfer_tgl), 32'd1);
    chk("t5_post_id",  32'(xfer_id),  32'd3);
    wait_done(base_done + 1, 30, "t5_wait");
    chk("t5_done_req3", 32'(done_cnt[3] - base_cnt[3]), 32'd1);
    step(6);

    // T6 random bursts against the clkb responder
    use_b = 1'b1;
    step(2);
    base_done = done_tot; base_ovf = ovf_tot; base_tmo = tmo_tot; base_l = launch_n;
    accepted   = 0;
    model_pend = '0;
    prev_tgl   = xfer_tgl;
    for (int cyc = 0; cyc < 400 && accepted < 10; cyc++) begin
      if (xfer_tgl !== prev_tgl) begin
        model_pend[xfer_id] = 1'b0;
        prev_tgl = xfer_tgl;
      end
      r = 4'($urandom) & ~model_pend;
      if ($urandom_range(0, 2) != 0) r = '0;
      req_a      = r;
      model_pend = model_pend | r;
      accepted   = accepted + $countones(r);
      step(1);
    end
    req_a = '0;
    wait_done(base_done + accepted, 3000, "t6_wait");
    step(4);
    chk("t6_enough",      32'(accepted >= 10), 32'd1);
    chk("t6_done_count",  32'(done_tot - base_done), 32'(accepted));
    chk("t6_launch_count", 32'(launch_n - base_l),   32'(accepted));
    chk("t6_no_ovf",      32'(ovf_tot - base_ovf),  32'd0);
    chk("t6_no_tmo",      32'(tmo_tot - base_tmo),  32'd0);
    chk("id_stable",      32'(id_viol),             32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
